// File: rtl/universal_shift_reg_burst.sv
// Universal shift register with rotate/arithmetic/clear modes and a counted burst engine.
// Optional serial-out flop SOUT is enabled by defining USR_SHIFT_OUT_EN.
module universal_shift_reg_burst #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       MODE,
   input  logic [WIDTH-1:0] D,
   input  logic             DL,
   input  logic             DR,
   input  logic             START,
   input  logic [CNT_W-1:0] CNT,
   output logic [WIDTH-1:0] Q,
   output logic             BUSY,
   output logic             DONE
`ifdef USR_SHIFT_OUT_EN
   ,
   output logic             SOUT
`endif
);

   localparam logic [2:0] ModeHold  = 3'b000;
   localparam logic [2:0] ModeShDn  = 3'b001;
   localparam logic [2:0] ModeShUp  = 3'b010;
   localparam logic [2:0] ModeLoad  = 3'b011;
   localparam logic [2:0] ModeRotDn = 3'b100;
   localparam logic [2:0] ModeRotUp = 3'b101;
   localparam logic [2:0] ModeAsr   = 3'b110;
   localparam logic [2:0] ModeClr   = 3'b111;

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [2:0]       mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_mode;

   function automatic logic is_shift(input logic [2:0] m);
      unique case (m)
         ModeShDn, ModeShUp, ModeRotDn, ModeRotUp, ModeAsr: is_shift = 1'b1;
         default:                                           is_shift = 1'b0;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] apply_mode(input logic [2:0]       m,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] d,
                                                   input logic             dl,
                                                   input logic             dr);
      unique case (m)
         ModeHold:  apply_mode = q;
         ModeShDn:  apply_mode = {dr, q[WIDTH-1:1]};
         ModeShUp:  apply_mode = {q[WIDTH-2:0], dl};
         ModeLoad:  apply_mode = d;
         ModeRotDn: apply_mode = {q[0], q[WIDTH-1:1]};
         ModeRotUp: apply_mode = {q[WIDTH-2:0], q[WIDTH-1]};
         ModeAsr:   apply_mode = {q[WIDTH-1], q[WIDTH-1:1]};
         ModeClr:   apply_mode = '0;
         default:   apply_mode = q;
      endcase
   endfunction

   // Mode actually applied this edge: latched mode in a burst, live MODE otherwise.
   assign op_mode = (state_q == StBurst) ? mode_q : MODE;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (START && is_shift(MODE)) begin
               if (CNT != '0) begin
                  mode_d  = MODE;
                  cnt_d   = CNT;
                  state_d = StBurst;
                  busy_d  = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               q_d = apply_mode(MODE, q_q, D, DL, DR);
            end
         end
         StBurst: begin
            q_d   = apply_mode(mode_q, q_q, D, DL, DR);
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = StIdle;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef USR_SHIFT_OUT_EN
   logic sout_q, sout_d;
   logic shift_edge;

   // A shift happens on every burst edge, or in idle when the mode runs (not a burst request).
   assign shift_edge = (state_q == StBurst) || (is_shift(MODE) && !START);

   always_comb begin
      sout_d = sout_q;
      if (shift_edge) begin
         unique case (op_mode)
            ModeShDn, ModeRotDn, ModeAsr: sout_d = q_q[0];
            ModeShUp, ModeRotUp:          sout_d = q_q[WIDTH-1];
            default:                      sout_d = sout_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) sout_q <= 1'b0;
      else       sout_q <= sout_d;
   end

   assign SOUT = sout_q;
`else
   logic unused_op_mode;
   assign unused_op_mode = ^op_mode;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         q_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mode_q  <= ModeHold;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Q    = q_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_universal_shift_reg_burst.sv
// Directed bench for universal_shift_reg_burst: arithmetic reference model checked every
// cycle, plus literal expectations taken from hand-worked vectors.
module tb_universal_shift_reg_burst;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    MODE  = 3'b011;
   logic [W-1:0]  D     = 8'hA5;
   logic          DL    = 1'b0;
   logic          DR    = 1'b0;
   logic          START = 1'b0;
   logic [CW-1:0] CNT   = '0;
   logic [W-1:0]  Q;
   logic          BUSY;
   logic          DONE;
`ifdef USR_SHIFT_OUT_EN
   logic          SOUT;
`endif

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   universal_shift_reg_burst #(.WIDTH(W), .CNT_W(CW)) dut (
      .clock(clock),
      .reset(reset),
      .MODE (MODE),
      .D    (D),
      .DL   (DL),
      .DR   (DR),
      .START(START),
      .CNT  (CNT),
      .Q    (Q),
      .BUSY (BUSY),
`ifdef USR_SHIFT_OUT_EN
      .DONE (DONE),
      .SOUT (SOUT)
`else
      .DONE (DONE)
`endif
   );

   always #5 clock = ~clock;

   // Reference model: integer arithmetic on the register value, a remaining-shift counter.
   int unsigned mq = 0;
   int unsigned msout = 0;
   int          left = 0;
   logic [2:0]  lmode = 3'b000;
   bit          mbusy = 1'b0;
   bit          mdone = 1'b0;

   function automatic int unsigned ref_op(input logic [2:0] m, input int unsigned q,
                                          input int unsigned d, input bit dl, input bit dr);
      int unsigned mask = (1 << W) - 1;
      case (m)
         3'd1:    return (q >> 1) | (int'(dr) << (W - 1));
         3'd2:    return ((q << 1) | int'(dl)) & mask;
         3'd3:    return d & mask;
         3'd4:    return (q >> 1) | ((q & 1) << (W - 1));
         3'd5:    return ((q << 1) | (q >> (W - 1))) & mask;
         3'd6:    return (q >> 1) | (q & (1 << (W - 1)));
         3'd7:    return 0;
         default: return q;
      endcase
   endfunction

   function automatic int unsigned ref_out(input logic [2:0] m, input int unsigned q,
                                           input int unsigned prev);
      if (m == 3'd1 || m == 3'd4 || m == 3'd6) return q & 1;
      if (m == 3'd2 || m == 3'd5) return (q >> (W - 1)) & 1;
      return prev;
   endfunction

   function automatic bit shift_class(input logic [2:0] m);
      return m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd5 || m == 3'd6;
   endfunction

   always @(posedge clock) begin
      mdone <= 1'b0;
      if (reset) begin
         mq <= 0; mbusy <= 1'b0; left <= 0; msout <= 0;
      end else if (left > 0) begin
         mq    <= ref_op(lmode, mq, D, DL, DR);
         msout <= ref_out(lmode, mq, msout);
         left  <= left - 1;
         mbusy <= (left > 1);
         mdone <= (left == 1);
      end else if (START && shift_class(MODE)) begin
         if (CNT != 0) begin
            left <= int'(CNT); lmode <= MODE; mbusy <= 1'b1;
         end else begin
            mdone <= 1'b1;
         end
      end else begin
         mq    <= ref_op(MODE, mq, D, DL, DR);
         msout <= ref_out(MODE, mq, msout);
      end
   end

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         check("model_q", Q, mq);
         check("model_busy", BUSY, mbusy);
         check("model_done", DONE, mdone);
`ifdef USR_SHIFT_OUT_EN
         check("model_sout", SOUT, msout);
`endif
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic drive(input logic [2:0] m, input logic [W-1:0] d, input bit dl, input bit dr,
                        input bit st, input logic [CW-1:0] c);
      MODE = m; D = d; DL = dl; DR = dr; START = st; CNT = c;
      tick();
   endtask

   initial begin
      tick();
      tick();
      check("reset_q", Q, 8'h00);
      check("reset_busy", BUSY, 0);
      check("reset_done", DONE, 0);
      reset = 1'b0;
      #3 chk_en = 1'b1;

      drive(3'd3, 8'hA5, 0, 0, 0, 0);
      drive(3'd1, 8'h00, 0, 1, 0, 0);
      check("shdn_d2", Q, 8'hD2);
      drive(3'd2, 8'h00, 0, 0, 0, 0);
      check("shup_a4", Q, 8'hA4);

      drive(3'd3, 8'h81, 0, 0, 0, 0);
      drive(3'd4, 8'h00, 0, 0, 0, 0);
      check("rotdn_c0", Q, 8'hC0);
      drive(3'd5, 8'h00, 0, 0, 0, 0);
      check("rotup_81", Q, 8'h81);
      drive(3'd3, 8'h80, 0, 0, 0, 0);
      drive(3'd6, 8'h00, 0, 0, 0, 0);
      check("asr_c0", Q, 8'hC0);
      drive(3'd7, 8'h00, 0, 0, 0, 0);
      check("clear_00", Q, 8'h00);

      // Sweep every mode with varied data and serial inputs.
      for (int i = 0; i < 16; i++) begin
         drive(3'(i % 8), 8'(8'h3C ^ (i * 37)), i[0], i[1], 0, 0);
      end

      // Three-shift rotate-up burst; MODE=load while busy must be ignored.
      drive(3'd3, 8'h01, 0, 0, 0, 0);
      drive(3'd5, 8'h00, 0, 0, 1, 4'd3);
      check("burst_accept_q", Q, 8'h01);
      check("burst_accept_busy", BUSY, 1);
      drive(3'd3, 8'hFF, 0, 0, 0, 0);
      check("burst_q1", Q, 8'h02);
      drive(3'd3, 8'hFF, 0, 0, 0, 0);
      check("burst_q2", Q, 8'h04);
      drive(3'd3, 8'hFF, 0, 0, 0, 0);
      check("burst_q3", Q, 8'h08);
      check("burst_done", DONE, 1);
      check("burst_busy_off", BUSY, 0);
      drive(3'd0, 8'h00, 0, 0, 0, 0);
      check("burst_hold_q", Q, 8'h08);
      check("burst_done_off", DONE, 0);

      // Zero-count start.
      drive(3'd1, 8'h00, 0, 1, 1, 4'd0);
      check("cnt0_done", DONE, 1);
      check("cnt0_q", Q, 8'h08);
      check("cnt0_busy", BUSY, 0);
      drive(3'd0, 8'h00, 0, 0, 0, 0);

      // START held during busy is ignored; DL changes mid-burst are honoured.
      drive(3'd2, 8'h00, 1, 0, 1, 4'd2);
      drive(3'd2, 8'h00, 1, 0, 1, 4'd5);
      check("busy_start_q", Q, 8'h11);
      drive(3'd0, 8'h00, 1, 0, 0, 0);
      check("busy_start_q2", Q, 8'h23);
      check("busy_start_done", DONE, 1);

      // Back-to-back: new burst accepted in the DONE cycle.
      drive(3'd1, 8'h00, 0, 0, 1, 4'd1);
      drive(3'd0, 8'h00, 0, 0, 0, 0);
      check("b2b_q1", Q, 8'h11);
      drive(3'd1, 8'h00, 0, 0, 1, 4'd1);
      check("b2b_rebusy", BUSY, 1);
      drive(3'd0, 8'h00, 0, 0, 0, 0);
      check("b2b_q2", Q, 8'h08);
      drive(3'd0, 8'h00, 0, 0, 0, 0);

      // Reset on the second shift of a five-shift burst.
      drive(3'd3, 8'hF0, 0, 0, 0, 0);
      drive(3'd2, 8'h00, 0, 0, 1, 4'd5);
      drive(3'd0, 8'h00, 0, 0, 0, 0);
      check("abort_first_shift", Q, 8'hE0);
      reset = 1'b1;
      drive(3'd0, 8'h00, 0, 0, 0, 0);
      reset = 1'b0;
      check("abort_q", Q, 8'h00);
      check("abort_busy", BUSY, 0);
      check("abort_done", DONE, 0);
      drive(3'd0, 8'h00, 0, 0, 0, 0);
      drive(3'd0, 8'h00, 0, 0, 0, 0);
      check("abort_no_done", DONE, 0);

`ifdef USR_SHIFT_OUT_EN
      drive(3'd3, 8'h01, 0, 0, 0, 0);
      drive(3'd1, 8'h00, 0, 0, 0, 0);
      check("sout_1", SOUT, 1);
      drive(3'd3, 8'h7F, 0, 0, 0, 0);
      check("sout_held", SOUT, 1);
      drive(3'd2, 8'h00, 0, 0, 0, 0);
      check("sout_0", SOUT, 0);
`endif

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
